// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM
// state encoding and the alignment check used at request time.
package lsu_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_RMW  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Undefined size codes are folded into the misaligned case so they
   // complete immediately without touching RAM.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         F3_B, F3_BU: mis = 1'b0;
         F3_H, F3_HU: mis = off[0];
         F3_W:        mis = (off != 2'b00);
         default:     mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load lane extract with sign/zero extend,
// and read-modify-write merge of a byte or half into the RAM word.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_mem_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_store
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed lane of the RAM word and extend it to 32 bits.
   always_comb begin
      byte_s = i_mem_rdata[{i_off, 3'b000} +: 8];
      half_s = i_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (i_funct3)
         F3_B:    o_load = {{24{byte_s[7]}}, byte_s};
         F3_BU:   o_load = {24'h000000, byte_s};
         F3_H:    o_load = {{16{half_s[15]}}, half_s};
         F3_HU:   o_load = {16'h0000, half_s};
         default: o_load = i_mem_rdata;
      endcase
   end

   // Overlay the store byte/half onto the current word, keeping other lanes.
   always_comb begin
      o_store = i_mem_rdata;
      case (i_funct3)
         F3_B, F3_BU: o_store[{i_off, 3'b000} +: 8]        = i_wdata[7:0];
         F3_H, F3_HU: o_store[{i_off[1], 4'b0000} +: 16]   = i_wdata[15:0];
         F3_W:        o_store = i_wdata;
         default:     o_store = i_mem_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the core and a word-wide RAM without byte
// enables. Sub-word stores are done as read-modify-write. All outputs are
// registered so the RAM and core see clean, glitch-free controls.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [2:0]        i_funct3,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   output logic              o_done,
   output logic              o_misaligned,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_mem_wr,
   input  logic [31:0]       i_mem_rdata
);

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          off_q, off_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                mem_wr_q, mem_wr_d;
   logic                done_q, done_d;
   logic                misaligned_q, misaligned_d;
   logic                busy_q, busy_d;
   logic [31:0]         load_s, store_s;
   logic                unused_addr_s;

   assign unused_addr_s = ^i_addr[31:ADDR_W+2];

   lsu_align u_align (
      .i_funct3    (funct3_q),
      .i_off       (off_q),
      .i_mem_rdata (i_mem_rdata),
      .i_wdata     (wdata_q),
      .o_load      (load_s),
      .o_store     (store_s)
   );

   // Next-state and registered-output computation for the access FSM.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      misaligned_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req) begin
               we_d       = i_we;
               funct3_d   = i_funct3;
               off_d      = i_addr[1:0];
               wdata_d    = i_wdata;
               mem_addr_d = i_addr[ADDR_W+1:2];
               if (is_misaligned(i_funct3, i_addr[1:0])) begin
                  state_d      = ST_DONE;
                  misaligned_d = 1'b1;
               end else if (!i_we) begin
                  state_d = ST_RD;
               end else if (i_funct3 == F3_W) begin
                  state_d     = ST_WR;
                  mem_wdata_d = i_wdata;
               end else begin
                  state_d = ST_RMW;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (!we_q) begin
               rdata_d = load_s;
            end else begin
               rdata_d = rdata_q;
            end
            state_d = ST_DONE;
         end
         ST_RMW: begin
            mem_wdata_d = store_s;
            state_d     = ST_WR;
         end
         ST_WR:   state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      done_d   = (state_d == ST_DONE);
      mem_wr_d = (state_d == ST_WR);
      busy_d   = (state_d != ST_IDLE);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         wdata_q      <= 32'h0000_0000;
         rdata_q      <= 32'h0000_0000;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'h0000_0000;
         mem_wr_q     <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wr_q     <= mem_wr_d;
         done_q       <= done_d;
         misaligned_q <= misaligned_d;
         busy_q       <= busy_d;
      end
   end

   assign o_rdata      = rdata_q;
   assign o_done       = done_q;
   assign o_misaligned = misaligned_q;
   assign o_busy       = busy_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single accesses against a
// small RAM model, plus hand sequences for busy-ignore and reset-in-RMW.
module tb_lsu_ctrl;

   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req;
   logic              i_we;
   logic [2:0]        i_funct3;
   logic [31:0]       i_addr;
   logic [31:0]       i_wdata;
   logic [31:0]       o_rdata;
   logic              o_done;
   logic              o_misaligned;
   logic              o_busy;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata;
   logic              o_mem_wr;
   logic [31:0]       i_mem_rdata;

   logic [31:0] mem [0:15];
   logic        ld_en = 1'b0;
   logic [3:0]  ld_idx = 4'd0;
   logic [31:0] ld_val = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_rdata;

   lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req        (i_req),
      .i_we         (i_we),
      .i_funct3     (i_funct3),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_rdata      (o_rdata),
      .o_done       (o_done),
      .o_misaligned (o_misaligned),
      .o_busy       (o_busy),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_wr     (o_mem_wr),
      .i_mem_rdata  (i_mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: combinational read, write on the strobe, bench preload port.
   assign i_mem_rdata = mem[o_mem_addr[3:0]];
   always @(posedge clk) begin
      if (ld_en) mem[ld_idx] <= ld_val;
      else if (o_mem_wr) mem[o_mem_addr[3:0]] <= o_mem_wdata;
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic        is_load;
      logic [31:0] exp_rdata;
      int          exp_cyc;
      logic        exp_mis;
      logic [31:0] exp_mem;
      int          exp_wr;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] init, logic is_load, logic [31:0] exp_rdata,
                               int exp_cyc, logic exp_mis, logic [31:0] exp_mem, int exp_wr);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.init = init;
      v.is_load = is_load; v.exp_rdata = exp_rdata; v.exp_cyc = exp_cyc;
      v.exp_mis = exp_mis; v.exp_mem = exp_mem; v.exp_wr = exp_wr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      ld_en = 1'b1; ld_idx = idx; ld_val = val;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic run_op(input int id, input vec_t v);
      int       done_cyc;
      int       wr_cnt;
      logic     mis_at;
      logic     outside_bad;
      logic     busy_bad;
      logic [3:0] idx;
      logic [31:0] exp_r;
      idx = v.addr[5:2];
      preload(idx, v.init);
      @(negedge clk);
      chk($sformatf("v%0d idle_busy", id), {31'd0, o_busy}, 32'd0);
      i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_addr = v.addr; i_wdata = v.wdata;
      done_cyc = -1; wr_cnt = 0; mis_at = 1'b0; outside_bad = 1'b0; busy_bad = 1'b0;
      for (int c = 1; c <= 6 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) i_req = 1'b0;
         if (o_mem_wr) wr_cnt++;
         if (!o_busy) busy_bad = 1'b1;
         if (o_done) begin
            done_cyc = c;
            mis_at = o_misaligned;
         end else if (o_misaligned) begin
            outside_bad = 1'b1;
         end
      end
      exp_r = v.is_load ? v.exp_rdata : last_rdata;
      chk($sformatf("v%0d done_cycle", id), done_cyc, v.exp_cyc);
      chk($sformatf("v%0d misaligned", id), {31'd0, mis_at}, {31'd0, v.exp_mis});
      chk($sformatf("v%0d rdata", id), o_rdata, exp_r);
      chk($sformatf("v%0d mem_word", id), mem[idx], v.exp_mem);
      chk($sformatf("v%0d wr_pulses", id), wr_cnt, v.exp_wr);
      chk($sformatf("v%0d mis_outside_done", id), {31'd0, outside_bad}, 32'd0);
      chk($sformatf("v%0d busy_drop", id), {31'd0, busy_bad}, 32'd0);
      last_rdata = exp_r;
   endtask

   initial begin
      int wr_cnt;
      rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000; i_addr = 32'h0; i_wdata = 32'h0;
      last_rdata = 32'h0;
      #1;
      chk("rst rdata", o_rdata, 32'h0);
      chk("rst mem_addr", {19'd0, o_mem_addr}, 32'h0);
      chk("rst mem_wdata", o_mem_wdata, 32'h0);
      chk("rst ctl", {28'd0, o_done, o_misaligned, o_busy, o_mem_wr}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      //          we    f3      addr   wdata         init          ld    exp_rdata     cyc mis  exp_mem       wr
      vecs[0]  = mk(1'b0, 3'b000, 32'h5, 32'h0,        32'h8899AABB, 1'b1, 32'hFFFFFFAA, 2, 1'b0, 32'h8899AABB, 0);
      vecs[1]  = mk(1'b0, 3'b101, 32'h6, 32'h0,        32'h8899AABB, 1'b1, 32'h00008899, 2, 1'b0, 32'h8899AABB, 0);
      vecs[2]  = mk(1'b0, 3'b100, 32'h4, 32'h0,        32'h8899AABB, 1'b1, 32'h000000BB, 2, 1'b0, 32'h8899AABB, 0);
      vecs[3]  = mk(1'b0, 3'b001, 32'h6, 32'h0,        32'h8899AABB, 1'b1, 32'hFFFF8899, 2, 1'b0, 32'h8899AABB, 0);
      vecs[4]  = mk(1'b0, 3'b001, 32'h4, 32'h0,        32'h8899AABB, 1'b1, 32'hFFFFAABB, 2, 1'b0, 32'h8899AABB, 0);
      vecs[5]  = mk(1'b0, 3'b010, 32'h4, 32'h0,        32'h8899AABB, 1'b1, 32'h8899AABB, 2, 1'b0, 32'h8899AABB, 0);
      vecs[6]  = mk(1'b0, 3'b000, 32'h7, 32'h0,        32'h8899AABB, 1'b1, 32'hFFFFFF88, 2, 1'b0, 32'h8899AABB, 0);
      vecs[7]  = mk(1'b0, 3'b010, 32'h6, 32'h0,        32'h8899AABB, 1'b0, 32'h0,        1, 1'b1, 32'h8899AABB, 0);
      vecs[8]  = mk(1'b1, 3'b000, 32'h9, 32'hEE,       32'h11223344, 1'b0, 32'h0,        3, 1'b0, 32'h1122EE44, 1);
      vecs[9]  = mk(1'b1, 3'b001, 32'hA, 32'h5566,     32'h11223344, 1'b0, 32'h0,        3, 1'b0, 32'h55663344, 1);
      vecs[10] = mk(1'b1, 3'b000, 32'hB, 32'h123456AB, 32'h11223344, 1'b0, 32'h0,        3, 1'b0, 32'hAB223344, 1);
      vecs[11] = mk(1'b1, 3'b001, 32'h8, 32'h0000CAFE, 32'h11223344, 1'b0, 32'h0,        3, 1'b0, 32'h1122CAFE, 1);
      vecs[12] = mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,       1'b0, 32'h0,        2, 1'b0, 32'hDEADBEEF, 1);
      vecs[13] = mk(1'b1, 3'b001, 32'h9, 32'hFFFF,     32'h11223344, 1'b0, 32'h0,        1, 1'b1, 32'h11223344, 0);
      vecs[14] = mk(1'b0, 3'b011, 32'h4, 32'h0,        32'h8899AABB, 1'b0, 32'h0,        1, 1'b1, 32'h8899AABB, 0);
      vecs[15] = mk(1'b1, 3'b110, 32'h8, 32'hFF,       32'h11223344, 1'b0, 32'h0,        1, 1'b1, 32'h11223344, 0);
      vecs[16] = mk(1'b0, 3'b001, 32'h3, 32'h0,        32'h8899AABB, 1'b0, 32'h0,        1, 1'b1, 32'h8899AABB, 0);
      vecs[17] = mk(1'b0, 3'b100, 32'h7, 32'h0,        32'h8899AABB, 1'b1, 32'h00000088, 2, 1'b0, 32'h8899AABB, 0);
      vecs[18] = mk(1'b1, 3'b010, 32'h12, 32'h01020304, 32'h0,       1'b0, 32'h0,        1, 1'b1, 32'h0,        0);

      for (int i = 0; i < 19; i++) run_op(i, vecs[i]);

      // A request raised while busy must be dropped, not queued.
      preload(4'd1, 32'h8899AABB);
      preload(4'd5, 32'h55555555);
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h4; i_wdata = 32'h0;
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h14; i_wdata = 32'h0;
      @(negedge clk);
      i_req = 1'b0;
      chk("busy_ign done", {31'd0, o_done}, 32'd1);
      chk("busy_ign rdata", o_rdata, 32'h8899AABB);
      wr_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (o_mem_wr) wr_cnt++;
      end
      chk("busy_ign wr", wr_cnt, 0);
      chk("busy_ign mem5", mem[5], 32'h55555555);
      chk("busy_ign idle", {31'd0, o_busy}, 32'd0);

      // Reset pulsed during the RMW read of a halfword store.
      preload(4'd2, 32'h11223344);
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'h8; i_wdata = 32'h0000BEEF;
      @(negedge clk);
      i_req = 1'b0;
      chk("rmw busy", {31'd0, o_busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rmw_rst rdata", o_rdata, 32'h0);
      chk("rmw_rst mem_addr", {19'd0, o_mem_addr}, 32'h0);
      chk("rmw_rst mem_wdata", o_mem_wdata, 32'h0);
      chk("rmw_rst ctl", {28'd0, o_done, o_misaligned, o_busy, o_mem_wr}, 32'h0);
      @(posedge clk); #1;
      chk("rmw_rst hold ctl", {28'd0, o_done, o_misaligned, o_busy, o_mem_wr}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      last_rdata = 32'h0;
      wr_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (o_mem_wr) wr_cnt++;
      end
      chk("rmw_rst wr", wr_cnt, 0);
      chk("rmw_rst mem2", mem[2], 32'h11223344);
      chk("rmw_rst idle", {31'd0, o_busy}, 32'd0);

      // Normal operation resumes after reset.
      run_op(99, mk(1'b0, 3'b010, 32'h8, 32'h0, 32'h11223344, 1'b1, 32'h11223344, 2, 1'b0, 32'h11223344, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
